count_sequencer: RTL and testbench

Controller that sequences the 10-bit up/down display counter through configurable sweeps. Each lap counts from a lower bound up to an upper bound in programmable steps, then back down. Laps repeat for a set count or indefinitely. It sits between the board-level control inputs (start/stop/pause) and the counter value driven to the display logic.

---
 rtl/count_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_count_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// count_sequencer: drives the display counter through repeated up/down
// sweeps between latched bounds. A lap runs lower -> upper in step_up
// increments, then back to lower in step_down decrements. Laps repeat
// for a latched count, or forever when that count is zero.
module count_sequencer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] lower,
  input  logic [WIDTH-1:0] upper,
  input  logic [3:0]       step_up,
  input  logic [3:0]       step_down,
  input  logic [3:0]       laps,
  output logic [WIDTH-1:0] out,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       rounds
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  // Lap counter increment that sticks at its maximum value.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val);
    if (val == 4'd15) begin
      sat_inc4 = 4'd15;
    end else begin
      sat_inc4 = val + 4'd1;
    end
  endfunction

  logic [1:0]       state_r;
  logic [WIDTH-1:0] out_r;
  logic             dir_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [3:0]       rounds_r;
  logic [WIDTH-1:0] lower_r;
  logic [WIDTH-1:0] upper_r;
  logic [3:0]       step_up_r;
  logic [3:0]       step_down_r;
  logic [3:0]       laps_r;

  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] out_nxt_s;
  logic [3:0]       rounds_nxt_s;
  logic             done_nxt_s;
  logic             err_nxt_s;
  logic             latch_s;
  logic             reject_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             lap_end_s;
  logic [3:0]       rounds_inc_s;

  // Step arithmetic one bit wider than the counter so neither direction
  // can wrap; the extra bit of diff_s is the borrow.
  assign sum_s        = {1'b0, out_r} + {{(WIDTH-3){1'b0}}, step_up_r};
  assign diff_s       = {1'b0, out_r} - {{(WIDTH-3){1'b0}}, step_down_r};
  assign lap_end_s    = diff_s[WIDTH] || (diff_s[WIDTH-1:0] <= lower_r);
  assign rounds_inc_s = sat_inc4(rounds_r);
  assign reject_s     = (upper <= lower) || (step_up == 4'd0) || (step_down == 4'd0);

  // Next-state and datapath decisions; stop outranks pause, pause outranks stepping.
  always_comb begin
    state_nxt_s  = state_r;
    out_nxt_s    = out_r;
    rounds_nxt_s = rounds_r;
    done_nxt_s   = 1'b0;
    err_nxt_s    = 1'b0;
    latch_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (reject_s) begin
            err_nxt_s = 1'b1;
          end else begin
            latch_s      = 1'b1;
            out_nxt_s    = lower;
            rounds_nxt_s = 4'd0;
            state_nxt_s  = ST_UP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_UP: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else if (pause) begin
          state_nxt_s = ST_UP;
        end else if (sum_s >= {1'b0, upper_r}) begin
          out_nxt_s   = upper_r;
          state_nxt_s = ST_DOWN;
        end else begin
          out_nxt_s = sum_s[WIDTH-1:0];
        end
      end
      ST_DOWN: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else if (pause) begin
          state_nxt_s = ST_DOWN;
        end else if (lap_end_s) begin
          out_nxt_s    = lower_r;
          rounds_nxt_s = rounds_inc_s;
          if ((laps_r != 4'd0) && (rounds_inc_s == laps_r)) begin
            state_nxt_s = ST_IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_UP;
          end
        end else begin
          out_nxt_s = diff_s[WIDTH-1:0];
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control and output registers; dir/busy are registered from the next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      out_r    <= {WIDTH{1'b0}};
      dir_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      rounds_r <= 4'd0;
    end else begin
      state_r  <= state_nxt_s;
      out_r    <= out_nxt_s;
      dir_r    <= (state_nxt_s == ST_UP);
      busy_r   <= (state_nxt_s == ST_UP) || (state_nxt_s == ST_DOWN);
      done_r   <= done_nxt_s;
      err_r    <= err_nxt_s;
      rounds_r <= rounds_nxt_s;
    end
  end

  // Sweep configuration captured only on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lower_r     <= {WIDTH{1'b0}};
      upper_r     <= {WIDTH{1'b0}};
      step_up_r   <= 4'd0;
      step_down_r <= 4'd0;
      laps_r      <= 4'd0;
    end else if (latch_s) begin
      lower_r     <= lower;
      upper_r     <= upper;
      step_up_r   <= step_up;
      step_down_r <= step_down;
      laps_r      <= laps;
    end else begin
      lower_r     <= lower_r;
      upper_r     <= upper_r;
      step_up_r   <= step_up_r;
      step_down_r <= step_down_r;
      laps_r      <= laps_r;
    end
  end

  assign out    = out_r;
  assign dir    = dir_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;
  assign rounds = rounds_r;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: each stimulus cycle pushes the
// hand-computed expected outputs; a monitor pops and compares them on the
// falling clock edge (or on demand for the asynchronous reset check).
module tb_count_sequencer;

  typedef struct packed {
    logic [9:0] out;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] rounds;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic [9:0] lower;
  logic [9:0] upper;
  logic [3:0] step_up;
  logic [3:0] step_down;
  logic [3:0] laps;
  logic [9:0] out;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] rounds;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  exp_v;
  exp_t  act_v;
  string tag_v;
  int    checks = 0;
  int    errors = 0;
  event  sample_ev;

  count_sequencer #(.WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .lower(lower), .upper(upper), .step_up(step_up), .step_down(step_down),
    .laps(laps), .out(out), .dir(dir), .busy(busy), .done(done),
    .err(err), .rounds(rounds)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare DUT outputs against the oldest expectation.
  always begin
    @(negedge clk or sample_ev);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tag_v = tag_q.pop_front();
      act_v = {out, dir, busy, done, err, rounds};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got out=%0d dir=%0b busy=%0b done=%0b err=%0b rounds=%0d, expected out=%0d dir=%0b busy=%0b done=%0b err=%0b rounds=%0d",
                 tag_v, act_v.out, act_v.dir, act_v.busy, act_v.done, act_v.err, act_v.rounds,
                 exp_v.out, exp_v.dir, exp_v.busy, exp_v.done, exp_v.err, exp_v.rounds);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // One clock: queue expectation for after the next rising edge, advance, clear start.
  task automatic cyc(input string tag, input logic [9:0] o, input logic d, input logic b,
                     input logic dn, input logic e, input logic [3:0] r);
    exp_t x;
    x = {o, d, b, dn, e, r};
    exp_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic cfg(input logic [9:0] lo, input logic [9:0] up, input logic [3:0] su,
                     input logic [3:0] sd, input logic [3:0] lp);
    lower = lo; upper = up; step_up = su; step_down = sd; laps = lp;
  endtask

  function automatic logic [3:0] sat15(input int n);
    logic [3:0] v;
    if (n > 15) v = 4'd15;
    else        v = n[3:0];
    return v;
  endfunction

  initial begin
    exp_t x;
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    cfg(10'd0, 10'd0, 4'd0, 4'd0, 4'd0);
    #1;
    cyc("reset_hold", 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    cyc("reset_idle", 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Basic lap; inputs scrambled after start must not matter.
    cfg(10'd0, 10'd10, 4'd3, 4'd4, 4'd1);
    start = 1'b1;
    cyc("basic_k0", 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cfg(10'd7, 10'd3, 4'd1, 4'd1, 4'd0);
    cyc("basic_k1", 10'd3,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("basic_k2", 10'd6,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("basic_k3", 10'd9,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("basic_k4", 10'd10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("basic_k5", 10'd6,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("basic_k6", 10'd2,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("basic_k7", 10'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
    cyc("basic_k8", 10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1);

    // Pause for three edges at out=6.
    cfg(10'd0, 10'd10, 4'd3, 4'd4, 4'd1);
    start = 1'b1;
    cyc("pause_k0", 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("pause_k1", 10'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("pause_k2", 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) cyc("pause_hold", 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    pause = 1'b0;
    cyc("pause_k6",  10'd9,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("pause_k7",  10'd10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("pause_k8",  10'd6,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("pause_k9",  10'd2,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("pause_k10", 10'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd1);

    // Rejected starts: equal bounds, zero step, inverted bounds.
    cfg(10'd5, 10'd5, 4'd3, 4'd4, 4'd1);
    start = 1'b1;
    cyc("rej_equal", 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    cyc("rej_clear", 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    cfg(10'd0, 10'd10, 4'd0, 4'd4, 4'd1);
    start = 1'b1;
    cyc("rej_step0", 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    cfg(10'd9, 10'd3, 4'd1, 4'd1, 4'd1);
    start = 1'b1;
    cyc("rej_invert", 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);

    // Start while busy ignored, then stop (with pause) during DOWN at 6.
    cfg(10'd0, 10'd10, 4'd3, 4'd4, 4'd1);
    start = 1'b1;
    cyc("ign_k0", 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cfg(10'd5, 10'd20, 4'd1, 4'd1, 4'd0);
    start = 1'b1;
    cyc("ign_busy", 10'd3,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("ign_k2",   10'd6,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("ign_k3",   10'd9,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("ign_k4",   10'd10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("ign_k5",   10'd6,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    stop = 1'b1; pause = 1'b1;
    cyc("stop_edge", 10'd6, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    stop = 1'b0; pause = 1'b0;
    cyc("stop_hold", 10'd6, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Width boundary, run forever; rounds saturates at 15.
    cfg(10'd1020, 10'd1023, 4'd15, 4'd15, 4'd0);
    start = 1'b1;
    cyc("wide_k0", 10'd1020, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int n = 1; n <= 17; n++) begin
      cyc("wide_top", 10'd1023, 1'b0, 1'b1, 1'b0, 1'b0, sat15(n - 1));
      cyc("wide_bot", 10'd1020, 1'b1, 1'b1, 1'b0, 1'b0, sat15(n));
    end

    // Asynchronous reset between edges while in UP.
    rst = 1'b0;
    x = '0;
    exp_q.push_back(x);
    tag_q.push_back("async_reset");
    #1;
    ->sample_ev;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Restart after reset: two laps, down step landing exactly on lower.
    cfg(10'd2, 10'd8, 4'd2, 4'd3, 4'd2);
    start = 1'b1;
    cyc("re_k0",  10'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("re_k1",  10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("re_k2",  10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("re_k3",  10'd8, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("re_k4",  10'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("re_k5",  10'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    cyc("re_k6",  10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    cyc("re_k7",  10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    cyc("re_k8",  10'd8, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    cyc("re_k9",  10'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    cyc("re_k10", 10'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    cyc("re_k11", 10'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
